// File: rtl/bcd_conv_arbiter.sv
// Round-robin front end that shares one binary-to-BCD encoder between
// NUM_REQ requesters. It accepts one operand at a time, drives the encoder
// handshake, returns the result to the winner, and aborts a conversion that
// never completes by resetting the encoder and flagging an error response.
`timescale 1ns/1ps
module bcd_conv_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BIN_WIDTH = 16,
  parameter int BCD_WIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*BIN_WIDTH-1:0] i_req_bin,
  output logic [NUM_REQ-1:0]           o_req_ack,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [BCD_WIDTH-1:0]         o_rsp_bcd,
  output logic                         o_rsp_err,
  output logic                         o_busy,
  output logic                         o_enc_begin,
  output logic [BIN_WIDTH-1:0]         o_enc_binary,
  output logic                         o_enc_rst,
  input  logic                         i_enc_done,
  input  logic [BCD_WIDTH-1:0]         i_enc_bcd
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);
  // The timer counts WAIT cycles starting at 0; leaving on the cycle it would
  // step to TIMEOUT-1 places RECOVER exactly TIMEOUT cycles after START.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RESP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        grant;
  logic [TW-1:0]        timer;
  logic                 armed;

  logic [BIN_WIDTH-1:0] operand [NUM_REQ];
  logic                 arb_found;
  logic [GW-1:0]        arb_idx;
  logic [GW-1:0]        cand;

  logic                 accept;
  logic                 complete;
  logic                 timeout;

  logic [NUM_REQ-1:0]   ack_nxt;
  logic [NUM_REQ-1:0]   valid_nxt;
  logic                 begin_nxt;
  logic                 err_nxt;
  logic                 enc_rst_nxt;
  logic                 busy_nxt;

  // Split the flat operand bus into one word per requester.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      operand[k] = i_req_bin[k*BIN_WIDTH +: BIN_WIDTH];
    end
  end

  // Round-robin search: first active request after the last served one.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!arb_found && i_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Handshake qualifiers; a real completion beats a timeout in the same cycle.
  always_comb begin
    accept   = (state == S_IDLE) && arb_found;
    complete = (state == S_WAIT) && armed && i_enc_done;
    timeout  = (state == S_WAIT) && !(armed && i_enc_done) && (timer == TIMER_LAST);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (arb_found) begin
          next_state = S_START;
        end
      end
      S_START: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (armed && i_enc_done) begin
          next_state = S_RESP;
        end else if (timer == TIMER_LAST) begin
          next_state = S_RECOVER;
        end
      end
      S_RESP: begin
        next_state = S_IDLE;
      end
      S_RECOVER: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Next values of the registered handshake outputs.
  always_comb begin
    ack_nxt     = '0;
    valid_nxt   = '0;
    begin_nxt   = 1'b0;
    err_nxt     = 1'b0;
    enc_rst_nxt = 1'b0;
    busy_nxt    = (next_state != S_IDLE);
    if (accept) begin
      ack_nxt[arb_idx] = 1'b1;
    end
    if (state == S_START) begin
      begin_nxt = 1'b1;
    end
    if (complete || timeout) begin
      valid_nxt[grant] = 1'b1;
    end
    if (timeout) begin
      err_nxt     = 1'b1;
      enc_rst_nxt = 1'b1;
    end
  end

  // Output registers for the pulse and status signals.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_req_ack   <= '0;
      o_rsp_valid <= '0;
      o_enc_begin <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_enc_rst   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_req_ack   <= ack_nxt;
      o_rsp_valid <= valid_nxt;
      o_enc_begin <= begin_nxt;
      o_rsp_err   <= err_nxt;
      o_enc_rst   <= enc_rst_nxt;
      o_busy      <= busy_nxt;
    end
  end

  // Grant bookkeeping; the winner becomes lowest priority once served.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant      <= '0;
      last_grant <= LAST_INIT;
    end else begin
      if (accept) begin
        grant <= arb_idx;
      end
      if (state == S_RESP || state == S_RECOVER) begin
        last_grant <= grant;
      end
    end
  end

  // WAIT timer and armed flag; armed ignores a done left over from before.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer <= '0;
      armed <= 1'b0;
    end else if (state == S_START) begin
      timer <= '0;
      armed <= 1'b0;
    end else if (state == S_WAIT) begin
      if (!i_enc_done) begin
        armed <= 1'b1;
      end
      if (!complete) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Operand and result holding registers; values persist between transactions.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_enc_binary <= '0;
      o_rsp_bcd    <= '0;
    end else begin
      if (accept) begin
        o_enc_binary <= operand[arb_idx];
      end
      if (complete) begin
        o_rsp_bcd <= i_enc_bcd;
      end else if (timeout) begin
        o_rsp_bcd <= '0;
      end
    end
  end

endmodule
